// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response and decode-side head.
// The slave modport is the fetch queue's view; master is the surrounding core/memory view.
interface riscv_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport slave (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output fetch_fault
  );

  modport master (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  fetch_fault
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: credit-based instruction prefetch queue with redirect flush and discard.
// Optional misaligned-redirect fault is enabled by defining FETCH_MISALIGN_CHK_EN.
module riscv_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  riscv_fetch_queue_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t        q_mem  [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [AW-1:0] q_rd, q_wr, pc_rd, pc_wr;
  logic [CW-1:0] occ, outst, outst_nxt, disc;
  logic [CW:0]   used;
  logic [31:0]   fetch_pc;
  logic [31:0]   redir_pc_al;
  logic          fault;
  logic          redir, req_vld, xfer, rsp, drop, push, pop, inst_vld;

  assign redir       = bus.redirect_valid;
  assign redir_pc_al = {bus.redirect_pc[31:2], 2'b00};
  assign rsp         = bus.imem_rsp_valid;

  // Credit covers both buffered entries and in-flight requests, so every
  // response always has a free slot.
  assign used    = {1'b0, occ} + {1'b0, outst};
  assign req_vld = rst_n && !redir && !fault && (used < DEPTH_W);
  assign xfer    = req_vld && bus.imem_req_ready;

  // Responses in the redirect cycle or still owed to an old path are dropped.
  assign drop     = redir || (disc != '0);
  assign push     = rsp && !drop;
  assign inst_vld = (occ != '0);
  assign pop      = inst_vld && bus.inst_ready && !redir;

  always_comb begin
    outst_nxt = outst;
    if (xfer && !rsp)      outst_nxt = outst + ONE_C;
    else if (rsp && !xfer) outst_nxt = outst - ONE_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      disc     <= '0;
      occ      <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      pc_rd    <= '0;
      pc_wr    <= '0;
    end else begin
      outst <= outst_nxt;
      // The PC FIFO tracks every request, discarded or not, so it stays in
      // lockstep with the in-order response stream across redirects.
      if (xfer) pc_wr <= pc_wr + ONE_P;
      if (rsp)  pc_rd <= pc_rd + ONE_P;
      if (redir) begin
        fetch_pc <= redir_pc_al;
        disc     <= outst_nxt;
        occ      <= '0;
        q_rd     <= '0;
        q_wr     <= '0;
      end else begin
        if (xfer)                fetch_pc <= fetch_pc + 32'd4;
        if (rsp && disc != '0)   disc     <= disc - ONE_C;
        if (push)                q_wr     <= q_wr + ONE_P;
        if (pop)                 q_rd     <= q_rd + ONE_P;
        if (push && !pop)        occ      <= occ + ONE_C;
        else if (pop && !push)   occ      <= occ - ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) pc_mem[pc_wr] <= fetch_pc;
    if (push) q_mem[q_wr]   <= '{data: bus.imem_rsp_data, pc: pc_mem[pc_rd]};
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Fault is sticky until the next aligned redirect; requests stay blocked meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fault <= 1'b0;
    else if (redir) fault <= |bus.redirect_pc[1:0];
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];
  assign fault         = 1'b0;
`endif

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = inst_vld;
  assign bus.inst_data      = q_mem[q_rd].data;
  assign bus.inst_pc        = q_mem[q_rd].pc;
  assign bus.fetch_fault    = fault;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == CW'(DEPTH)));
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    used <= DEPTH_W);

endmodule
